// File: rtl/crc16_pkg.sv
// CRC-16 (poly 0x8005, MSB first, no reflection, no final XOR) shared definitions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: polynomial/seed constants, hold/output register structs, and the
// 32-bit parallel next-state function shared by the TX generator and RX checker.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Candidate payload word waiting for its successor (which tells us whether it is last).
    typedef struct packed {
        logic [31:0] dat;
        logic        sop;
    } hold_t;

    // Downstream output register contents.
    typedef struct packed {
        logic [31:0] dat;
        logic        sop;
        logic        eop;
        logic        err;
    } out_t;

    // Folds one 32-bit word into the CRC, data bit 31 first.
    function automatic logic [15:0] crc16_d32_next(input logic [15:0] crc, input logic [31:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_d32_next_comb.sv
// Combinational CRC-16 next-state for one 32-bit word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: crc_in (current CRC), data_in (word to fold in), crc_out (updated CRC).
module crc16_d32_next_comb
    import crc16_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [31:0] data_in,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_d32_next(crc_in, data_in);

endmodule

// File: rtl/crc16_d32_frame_checker.sv
// RX CRC-16 checker: strips the trailer word, forwards payload, flags last word pass/fail.
// Latency: payload word k is presented one cycle after word k+1 (or trailer) is accepted.
// Backpressure: s_ready drops only while a word is held and the output register is stalled.
//
// Ports: clk/rst (async active-high); s_* upstream stream (s_eop marks the trailer);
// m_* payload stream with m_crc_err valid on m_eop; frame_ok/frame_bad one-cycle pulses;
// good_cnt/bad_cnt/drop_cnt saturating statistics.
module crc16_d32_frame_checker
    import crc16_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [15:0] CRC_INIT = CRC16_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_sop,
    input  logic             s_eop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_sop,
    output logic             m_eop,
    output logic             m_crc_err,
    output logic             frame_ok,
    output logic             frame_bad,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    hold_t            hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    out_t             out_q, out_d;
    logic             out_vld_q, out_vld_d;
    logic [15:0]      crc_q, crc_d, crc_nxt;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_bad_q, frame_bad_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             o_free, acc, crc_mis;
    logic             good_inc, bad_inc, drop_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
    endfunction

    assign o_free  = !out_vld_q | m_ready;
    assign s_ready = !hold_vld_q | o_free;
    assign acc     = s_valid & s_ready;

    // CRC including the held word, i.e. the value the trailer must match.
    crc16_d32_next_comb u_crc (
        .crc_in  (crc_q),
        .data_in (hold_q.dat),
        .crc_out (crc_nxt)
    );

    assign crc_mis = (crc_nxt != s_data[15:0]);

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q & !m_ready;
        crc_d      = crc_q;
        good_inc   = 1'b0;
        bad_inc    = 1'b0;
        drop_inc   = 1'b0;

        if (acc) begin
            if (!hold_vld_q) begin
                if (s_sop && !s_eop) begin
                    hold_d     = '{dat: s_data, sop: 1'b1};
                    hold_vld_d = 1'b1;
                    crc_d      = CRC_INIT;
                end else begin
                    // Runt or word outside any frame.
                    drop_inc = 1'b1;
                end
            end else begin
                // Any accepted word finalises the held one; s_ready guarantees O is free.
                out_vld_d = 1'b1;
                out_d     = '{dat: hold_q.dat, sop: hold_q.sop, eop: 1'b1, err: 1'b0};
                if (!s_sop && !s_eop) begin
                    out_d.eop = 1'b0;
                    crc_d     = crc_nxt;
                    hold_d    = '{dat: s_data, sop: 1'b0};
                end else if (!s_sop) begin
                    out_d.err  = crc_mis;
                    hold_vld_d = 1'b0;
                    good_inc   = !crc_mis;
                    bad_inc    = crc_mis;
                end else begin
                    // New sop before a trailer: the previous frame is aborted.
                    out_d.err = 1'b1;
                    bad_inc   = 1'b1;
                    if (!s_eop) begin
                        hold_d = '{dat: s_data, sop: 1'b1};
                        crc_d  = CRC_INIT;
                    end else begin
                        hold_vld_d = 1'b0;
                        drop_inc   = 1'b1;
                    end
                end
            end
        end

        frame_ok_d  = good_inc;
        frame_bad_d = bad_inc;
        good_cnt_d  = sat_inc(good_cnt_q, good_inc);
        bad_cnt_d   = sat_inc(bad_cnt_q, bad_inc);
        drop_cnt_d  = sat_inc(drop_cnt_q, drop_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            crc_q       <= CRC_INIT;
            frame_ok_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            crc_q       <= crc_d;
            frame_ok_q  <= frame_ok_d;
            frame_bad_q <= frame_bad_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign m_valid   = out_vld_q;
    assign m_data    = out_q.dat;
    assign m_sop     = out_q.sop;
    assign m_eop     = out_q.eop;
    assign m_crc_err = out_q.err;
    assign frame_ok  = frame_ok_q;
    assign frame_bad = frame_bad_q;
    assign good_cnt  = good_cnt_q;
    assign bad_cnt   = bad_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_crc16_d32_frame_checker.sv
// Self-checking bench for crc16_d32_frame_checker: frame vector table, hand-written
// abort/runt/reset sequences, and a long randomised frame under random backpressure.
// Reference CRC is computed by polynomial long division over the whole frame's bits.
module tb_crc16_d32_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_sop, s_eop;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_sop, m_eop, m_crc_err;
    logic [31:0] m_data;
    logic        frame_ok, frame_bad;
    logic [15:0] good_cnt, bad_cnt, drop_cnt;

    crc16_d32_frame_checker dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop),
        .m_crc_err(m_crc_err), .frame_ok(frame_ok), .frame_bad(frame_bad),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic        sop;
        logic        eop;
        logic        err;
    } exp_t;

    typedef struct {
        int          n;
        logic [31:0] w[4];
        logic [15:0] mask;
        logic        exp_err;
    } vec_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0, n_fail = 0;
    int   ok_seen = 0, bad_seen = 0;
    int   exp_good = 0, exp_bad = 0, exp_drop = 0;
    bit   rand_ready = 0;
    bit   rand_gaps = 0;

    // Reference CRC: remainder of (init*x^n + M*x^16) / (x^16+x^15+x^2+1).
    function automatic logic [15:0] model_crc(input logic [31:0] w[$]);
        bit          b[$];
        logic [16:0] p;
        logic [15:0] init, r;
        int          n;
        p = 17'h18005;
        init = 16'hFFFF;
        foreach (w[k]) for (int i = 31; i >= 0; i--) b.push_back(w[k][i]);
        n = b.size();
        for (int i = 0; i < 16; i++) b.push_back(1'b0);
        for (int i = 0; i < 16; i++) b[i] = b[i] ^ init[15-i];
        for (int i = 0; i < n; i++)
            if (b[i]) for (int j = 0; j < 17; j++) b[i+j] = b[i+j] ^ p[16-j];
        for (int i = 0; i < 16; i++) r[15-i] = b[n+i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Output monitor, sampled mid-cycle after the ready driver has settled.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_word: unexpected word %h sop=%0b eop=%0b", m_data, m_sop, m_eop);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.dat || m_sop !== e.sop || m_eop !== e.eop ||
                        (m_eop && m_crc_err !== e.err)) begin
                        n_fail++;
                        $display("FAIL out_word: got %h/%0b/%0b/%0b expected %h/%0b/%0b/%0b",
                                 m_data, m_sop, m_eop, m_crc_err, e.dat, e.sop, e.eop, e.err);
                    end
                end
            end
            if (frame_ok) ok_seen++;
            if (frame_bad) bad_seen++;
            n_cmp++;
            if (!s_ready && !(m_valid && !m_ready)) begin
                n_fail++;
                $display("FAIL s_ready_low: got s_ready=0 with m_valid=%0b m_ready=%0b", m_valid, m_ready);
            end
        end
    end

    always @(negedge clk) m_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic send(input logic [31:0] d, input logic sop, input logic eop);
        int tries = 0;
        if (rand_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop;
        forever begin
            #1;
            if (s_ready) break;
            tries++;
            if (tries > 500) begin
                n_cmp++; n_fail++;
                $display("FAIL send_timeout: s_ready=0 for %0d cycles, expected acceptance", tries);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    function automatic void push_exp(input logic [31:0] d, input logic sop, input logic eop, input logic err);
        exp_t x;
        x.dat = d; x.sop = sop; x.eop = eop; x.err = err;
        exp_q.push_back(x);
    endfunction

    task automatic send_frame(input logic [31:0] w[$], input logic [15:0] mask, input logic exp_err);
        logic [15:0] c;
        c = model_crc(w);
        foreach (w[i]) push_exp(w[i], i == 0, i == w.size() - 1, exp_err);
        if (exp_err) exp_bad++; else exp_good++;
        foreach (w[i]) send(w[i], i == 0, 1'b0);
        send({16'($urandom), c ^ mask}, 1'b0, 1'b1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #3;
        check({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic check_stats(input string name);
        check({name, "_good_cnt"}, good_cnt, exp_good);
        check({name, "_bad_cnt"}, bad_cnt, exp_bad);
        check({name, "_drop_cnt"}, drop_cnt, exp_drop);
        check({name, "_ok_pulses"}, ok_seen, exp_good);
        check({name, "_bad_pulses"}, bad_seen, exp_bad);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_good = 0; exp_bad = 0; exp_drop = 0;
        ok_seen = 0; bad_seen = 0;
        repeat (2) @(negedge clk);
        #3;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_outs", {m_data, m_sop, m_eop, m_crc_err}, 0);
        check("rst_pulses", {frame_ok, frame_bad}, 0);
        check("rst_counters", {good_cnt, bad_cnt, drop_cnt}, 0);
        check("rst_s_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [31:0] w[$];

        vecs[0] = '{n: 3, w: '{32'hA5A5A5A5, 32'h00000001, 32'hDEADBEEF, 32'h0}, mask: 16'h0000, exp_err: 1'b0};
        vecs[1] = '{n: 3, w: '{32'hA5A5A5A5, 32'h00000001, 32'hDEADBEEF, 32'h0}, mask: 16'h0001, exp_err: 1'b1};
        vecs[2] = '{n: 1, w: '{32'h12345678, 32'h0, 32'h0, 32'h0}, mask: 16'h0000, exp_err: 1'b0};
        vecs[3] = '{n: 4, w: '{32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h00000001}, mask: 16'h0000, exp_err: 1'b0};
        vecs[4] = '{n: 2, w: '{32'h0BADF00D, 32'hCAFEBABE, 32'h0, 32'h0}, mask: 16'h8000, exp_err: 1'b1};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sop = 1'b0; s_eop = 1'b0;
        do_reset();

        // Table: each frame checked separately from a fresh reset.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            w.delete();
            for (int i = 0; i < vecs[v].n; i++) w.push_back(vecs[v].w[i]);
            send_frame(w, vecs[v].mask, vecs[v].exp_err);
            drain($sformatf("vec%0d", v));
            check_stats($sformatf("vec%0d", v));
        end

        // One-word frame followed by a runt and an out-of-frame word.
        do_reset();
        w.delete(); w.push_back(32'h13579BDF);
        send_frame(w, 16'h0, 1'b0);
        send(32'h11111111, 1'b1, 1'b1); exp_drop++;
        send(32'h22222222, 1'b0, 1'b0); exp_drop++;
        drain("runt");
        check_stats("runt");

        // Frame aborted by a new sop, then a good frame.
        do_reset();
        send(32'hAAAA0001, 1'b1, 1'b0);
        send(32'hAAAA0002, 1'b0, 1'b0);
        push_exp(32'hAAAA0001, 1'b1, 1'b0, 1'b0);
        push_exp(32'hAAAA0002, 1'b0, 1'b1, 1'b1);
        exp_bad++;
        w.delete(); w.push_back(32'hBBBB0001); w.push_back(32'hBBBB0002);
        send_frame(w, 16'h0, 1'b0);
        drain("abort");
        check_stats("abort");

        // Abort where the new sop word is itself a runt: bad and drop together.
        do_reset();
        send(32'hC0000001, 1'b1, 1'b0);
        send(32'hC0000002, 1'b0, 1'b0);
        push_exp(32'hC0000001, 1'b1, 1'b0, 1'b0);
        push_exp(32'hC0000002, 1'b0, 1'b1, 1'b1);
        send(32'hC0000003, 1'b1, 1'b1);
        exp_bad++; exp_drop++;
        drain("abort_runt");
        check_stats("abort_runt");

        // Long random frames under random backpressure and input gaps.
        do_reset();
        rand_ready = 1; rand_gaps = 1;
        w.delete();
        for (int i = 0; i < 64; i++) w.push_back($urandom);
        send_frame(w, 16'h0, 1'b0);
        w.delete();
        for (int i = 0; i < 10; i++) w.push_back($urandom);
        send_frame(w, 16'($urandom_range(1, 16'hFFFF)), 1'b1);
        rand_ready = 0; rand_gaps = 0;
        drain("random");
        check_stats("random");

        // Reset mid-frame after 5 words; the held word must never appear.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(32'hD0000000 + i, i == 0, 1'b0);
            if (i < 4) push_exp(32'hD0000000 + i, i == 0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        #3;
        check("midrst_emitted", exp_q.size(), 0);
        @(negedge clk);
        #3 rst = 1'b1;
        do_reset();
        w.delete(); w.push_back(32'hE0000001); w.push_back(32'hE0000002); w.push_back(32'hE0000003);
        send_frame(w, 16'h0, 1'b0);
        drain("midrst");
        check_stats("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
